// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: stall vectors, exception codes, FSM states.
package pipe_ctrl_pkg;

  // Stall vector bit order: [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_ALL  = 6'b111111;

  localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_BREAK   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI      = 32'h0000_000a;
  localparam logic [31:0] EXC_OV      = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MC_BUSY = 2'd1,
    ST_FREEZE  = 2'd2,
    ST_FLUSH   = 2'd3
  } state_t;

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Counts consecutive PC-stall cycles; raises a sticky flag at STALL_TIMEOUT.
// Counter saturates; flag clears only on reset or a clear pulse (pipeline flush).
module stall_watchdog #(
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_pc,
  input  logic clear,
  output logic timeout
);

  localparam int W = $clog2(STALL_TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(STALL_TIMEOUT);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = '0;
    if (stall_pc) begin
      cnt_nxt = (cnt == LIMIT) ? cnt : cnt + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (clear) begin
        timeout <= 1'b0;
      end else if (cnt_nxt == LIMIT) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stall requests, counts multi-cycle EX ops and
// turns MEM-stage exceptions into a freeze-then-flush with a redirect PC.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR    = EXC_VECTOR_DEF,
  parameter int          STALL_TIMEOUT = 1024,
  parameter int          CNT_W         = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             ex_mc_start,
  input  logic [CNT_W-1:0] ex_mc_len,
  input  logic [31:0]      excepttype_i,
  input  logic [31:0]      cp0_epc_i,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic [CNT_W-1:0] ex_mc_cnt,
  output logic             ex_mc_done,
  output logic             stall_timeout
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] len_q, len_nxt, cnt_nxt;
  logic [31:0]      new_pc_nxt;
  logic [5:0]       stall_c;
  logic             exc_take, last, mc_req, done_c;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = ex_mc_cnt;
    len_nxt    = len_q;
    new_pc_nxt = new_pc;
    stall_c    = STALL_NONE;
    done_c     = 1'b0;
    mc_req     = 1'b0;
    last       = (ex_mc_cnt == len_q - CNT_W'(1));
    exc_take   = ((state == ST_RUN) || (state == ST_MC_BUSY)) &&
                 (excepttype_i != EXC_NONE) && !stallreq_mem;

    if (state == ST_RUN)     mc_req = ex_mc_start;
    if (state == ST_MC_BUSY) mc_req = !last;

    // FREEZE/FLUSH ignore every request; otherwise the deepest request wins.
    if      (state == ST_FREEZE)          stall_c = STALL_ALL;
    else if (state == ST_FLUSH)           stall_c = STALL_NONE;
    else if (exc_take)                    stall_c = STALL_ALL;
    else if (stallreq_mem)                stall_c = STALL_MEM;
    else if (stallreq_ex || mc_req)       stall_c = STALL_EX;
    else if (stallreq_id)                 stall_c = STALL_ID;
    else if (stallreq_if)                 stall_c = STALL_IF;

    done_c = (state == ST_MC_BUSY) && last && !exc_take;

    if (exc_take) begin
      state_nxt  = ST_FREEZE;
      cnt_nxt    = '0;
      new_pc_nxt = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
    end else begin
      case (state)
        ST_RUN: begin
          if (ex_mc_start && !stall_c[4]) begin
            state_nxt = ST_MC_BUSY;
            len_nxt   = (ex_mc_len == '0) ? CNT_W'(1) : ex_mc_len;
            cnt_nxt   = '0;
          end
        end
        ST_MC_BUSY: begin
          if (!stall_c[4]) begin
            if (last) begin
              state_nxt = ST_RUN;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = ex_mc_cnt + CNT_W'(1);
            end
          end
        end
        ST_FREEZE: state_nxt = ST_FLUSH;
        ST_FLUSH:  state_nxt = ST_RUN;
        default:   state_nxt = ST_RUN;
      endcase
    end
  end

  assign stall      = rst ? stall_c : STALL_NONE;
  assign ex_mc_done = rst & done_c;
  assign flush      = (state == ST_FLUSH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      ex_mc_cnt <= '0;
      len_q     <= '0;
      new_pc    <= '0;
    end else begin
      state     <= state_nxt;
      ex_mc_cnt <= cnt_nxt;
      len_q     <= len_nxt;
      new_pc    <= new_pc_nxt;
    end
  end

  stall_watchdog #(
    .STALL_TIMEOUT(STALL_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .stall_pc(stall[0]),
    .clear   (flush),
    .timeout (stall_timeout)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: inputs change and outputs are sampled just after the falling edge.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        ex_mc_start;
  logic [5:0]  ex_mc_len;
  logic [31:0] excepttype_i, cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [5:0]  ex_mc_cnt;
  logic        ex_mc_done;
  logic        stall_timeout;

  int n_cmp = 0;
  int n_err = 0;

  pipe_ctrl #(
    .EXC_VECTOR   (32'h0000_0020),
    .STALL_TIMEOUT(8),
    .CNT_W        (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .ex_mc_start  (ex_mc_start),
    .ex_mc_len    (ex_mc_len),
    .excepttype_i (excepttype_i),
    .cp0_epc_i    (cp0_epc_i),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .ex_mc_cnt    (ex_mc_cnt),
    .ex_mc_done   (ex_mc_done),
    .stall_timeout(stall_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stallreq_if  = 1'b0;
    stallreq_id  = 1'b0;
    stallreq_ex  = 1'b0;
    stallreq_mem = 1'b0;
    ex_mc_start  = 1'b0;
    ex_mc_len    = 6'd0;
    excepttype_i = 32'h0;
    cp0_epc_i    = 32'h0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst          = 1'b0;
    stallreq_mem = 1'b1;
    ex_mc_start  = 1'b1;
    ex_mc_len    = 6'd3;
    #2;
    n_cmp++; if (stall !== 6'b000000) begin n_err++; $display("FAIL rst_stall got=%b exp=000000", stall); end
    n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL rst_flush got=%b exp=0", flush); end
    n_cmp++; if (new_pc !== 32'h0) begin n_err++; $display("FAIL rst_new_pc got=%h exp=0", new_pc); end
    n_cmp++; if (ex_mc_cnt !== 6'd0) begin n_err++; $display("FAIL rst_cnt got=%0d exp=0", ex_mc_cnt); end
    n_cmp++; if (ex_mc_done !== 1'b0) begin n_err++; $display("FAIL rst_done got=%b exp=0", ex_mc_done); end
    n_cmp++; if (stall_timeout !== 1'b0) begin n_err++; $display("FAIL rst_timeout got=%b exp=0", stall_timeout); end
    next_cycle();
    clear_inputs();
    next_cycle();
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_priority();
    next_cycle();
    stallreq_id = 1'b1; stallreq_mem = 1'b1; #1;
    n_cmp++; if (stall !== 6'b011111) begin n_err++; $display("FAIL prio_mem_id got=%b exp=011111", stall); end
    next_cycle();
    stallreq_mem = 1'b0; #1;
    n_cmp++; if (stall !== 6'b000111) begin n_err++; $display("FAIL prio_id got=%b exp=000111", stall); end
    next_cycle();
    stallreq_id = 1'b0; stallreq_if = 1'b1; #1;
    n_cmp++; if (stall !== 6'b000011) begin n_err++; $display("FAIL prio_if got=%b exp=000011", stall); end
    next_cycle();
    stallreq_ex = 1'b1; #1;
    n_cmp++; if (stall !== 6'b001111) begin n_err++; $display("FAIL prio_ex_if got=%b exp=001111", stall); end
    // start under a MEM stall is dropped: no op begins
    next_cycle();
    clear_inputs(); stallreq_mem = 1'b1; ex_mc_start = 1'b1; ex_mc_len = 6'd2; #1;
    n_cmp++; if (stall !== 6'b011111) begin n_err++; $display("FAIL prio_start_mem got=%b exp=011111", stall); end
    next_cycle();
    clear_inputs(); #1;
    n_cmp++; if (stall !== 6'b000000) begin n_err++; $display("FAIL prio_start_dropped got=%b exp=000000", stall); end
    n_cmp++; if (ex_mc_done !== 1'b0) begin n_err++; $display("FAIL prio_start_dropped_done got=%b exp=0", ex_mc_done); end
  endtask

  task automatic test_madd();
    next_cycle();
    ex_mc_start = 1'b1; ex_mc_len = 6'd2; #1;
    n_cmp++; if (stall !== 6'b001111) begin n_err++; $display("FAIL madd_start_stall got=%b exp=001111", stall); end
    next_cycle();
    clear_inputs(); #1;
    n_cmp++; if (stall !== 6'b001111) begin n_err++; $display("FAIL madd_b0_stall got=%b exp=001111", stall); end
    n_cmp++; if (ex_mc_cnt !== 6'd0) begin n_err++; $display("FAIL madd_b0_cnt got=%0d exp=0", ex_mc_cnt); end
    n_cmp++; if (ex_mc_done !== 1'b0) begin n_err++; $display("FAIL madd_b0_done got=%b exp=0", ex_mc_done); end
    next_cycle();
    n_cmp++; if (ex_mc_cnt !== 6'd1) begin n_err++; $display("FAIL madd_b1_cnt got=%0d exp=1", ex_mc_cnt); end
    n_cmp++; if (ex_mc_done !== 1'b1) begin n_err++; $display("FAIL madd_b1_done got=%b exp=1", ex_mc_done); end
    n_cmp++; if (stall !== 6'b000000) begin n_err++; $display("FAIL madd_b1_stall got=%b exp=000000", stall); end
    next_cycle();
    n_cmp++; if (ex_mc_done !== 1'b0) begin n_err++; $display("FAIL madd_run_done got=%b exp=0", ex_mc_done); end
    n_cmp++; if (ex_mc_cnt !== 6'd0) begin n_err++; $display("FAIL madd_run_cnt got=%0d exp=0", ex_mc_cnt); end
  endtask

  task automatic test_len_zero();
    next_cycle();
    ex_mc_start = 1'b1; ex_mc_len = 6'd0; #1;
    n_cmp++; if (stall !== 6'b001111) begin n_err++; $display("FAIL len0_start_stall got=%b exp=001111", stall); end
    next_cycle();
    clear_inputs(); #1;
    n_cmp++; if (ex_mc_done !== 1'b1) begin n_err++; $display("FAIL len0_done got=%b exp=1", ex_mc_done); end
    n_cmp++; if (stall !== 6'b000000) begin n_err++; $display("FAIL len0_stall got=%b exp=000000", stall); end
    next_cycle();
    n_cmp++; if (ex_mc_done !== 1'b0) begin n_err++; $display("FAIL len0_after_done got=%b exp=0", ex_mc_done); end
  endtask

  task automatic test_mc_mem_stall();
    next_cycle();
    ex_mc_start = 1'b1; ex_mc_len = 6'd3; #1;
    next_cycle();
    clear_inputs(); #1;
    n_cmp++; if (ex_mc_cnt !== 6'd0) begin n_err++; $display("FAIL mcmem_b0_cnt got=%0d exp=0", ex_mc_cnt); end
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      stallreq_mem = 1'b1; #1;
      n_cmp++; if (stall !== 6'b011111) begin n_err++; $display("FAIL mcmem_hold%0d_stall got=%b exp=011111", i, stall); end
      n_cmp++; if (ex_mc_cnt !== 6'd1) begin n_err++; $display("FAIL mcmem_hold%0d_cnt got=%0d exp=1", i, ex_mc_cnt); end
      n_cmp++; if (ex_mc_done !== 1'b0) begin n_err++; $display("FAIL mcmem_hold%0d_done got=%b exp=0", i, ex_mc_done); end
    end
    next_cycle();
    stallreq_mem = 1'b0; #1;
    n_cmp++; if (stall !== 6'b001111) begin n_err++; $display("FAIL mcmem_resume_stall got=%b exp=001111", stall); end
    n_cmp++; if (ex_mc_cnt !== 6'd1) begin n_err++; $display("FAIL mcmem_resume_cnt got=%0d exp=1", ex_mc_cnt); end
    next_cycle();
    n_cmp++; if (ex_mc_cnt !== 6'd2) begin n_err++; $display("FAIL mcmem_last_cnt got=%0d exp=2", ex_mc_cnt); end
    n_cmp++; if (ex_mc_done !== 1'b1) begin n_err++; $display("FAIL mcmem_last_done got=%b exp=1", ex_mc_done); end
    next_cycle();
    n_cmp++; if (ex_mc_done !== 1'b0) begin n_err++; $display("FAIL mcmem_run_done got=%b exp=0", ex_mc_done); end
  endtask

  task automatic test_exception();
    next_cycle();
    ex_mc_start = 1'b1; ex_mc_len = 6'd4; #1;
    next_cycle();
    clear_inputs(); #1;
    next_cycle();
    excepttype_i = 32'h0000_000c; #1;
    n_cmp++; if (stall !== 6'b111111) begin n_err++; $display("FAIL exc_detect_stall got=%b exp=111111", stall); end
    n_cmp++; if (ex_mc_done !== 1'b0) begin n_err++; $display("FAIL exc_detect_done got=%b exp=0", ex_mc_done); end
    n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL exc_detect_flush got=%b exp=0", flush); end
    next_cycle();
    stallreq_mem = 1'b1; #1;
    n_cmp++; if (stall !== 6'b111111) begin n_err++; $display("FAIL exc_freeze_stall got=%b exp=111111", stall); end
    n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL exc_freeze_flush got=%b exp=0", flush); end
    n_cmp++; if (ex_mc_cnt !== 6'd0) begin n_err++; $display("FAIL exc_freeze_cnt got=%0d exp=0", ex_mc_cnt); end
    next_cycle();
    n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL exc_flush got=%b exp=1", flush); end
    n_cmp++; if (new_pc !== 32'h0000_0020) begin n_err++; $display("FAIL exc_new_pc got=%h exp=00000020", new_pc); end
    n_cmp++; if (stall !== 6'b000000) begin n_err++; $display("FAIL exc_flush_stall got=%b exp=000000", stall); end
    n_cmp++; if (ex_mc_done !== 1'b0) begin n_err++; $display("FAIL exc_flush_done got=%b exp=0", ex_mc_done); end
    next_cycle();
    clear_inputs(); #1;
    n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL exc_after_flush got=%b exp=0", flush); end
    n_cmp++; if (ex_mc_done !== 1'b0) begin n_err++; $display("FAIL exc_after_done got=%b exp=0", ex_mc_done); end
    n_cmp++; if (stall !== 6'b000000) begin n_err++; $display("FAIL exc_after_stall got=%b exp=000000", stall); end
  endtask

  task automatic test_eret();
    next_cycle();
    excepttype_i = 32'h0000_000e; cp0_epc_i = 32'h0000_1234; stallreq_mem = 1'b1; #1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (stall !== 6'b011111) begin n_err++; $display("FAIL eret_memwait%0d_stall got=%b exp=011111", i, stall); end
      next_cycle();
      n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL eret_memwait%0d_flush got=%b exp=0", i, flush); end
    end
    stallreq_mem = 1'b0; ex_mc_start = 1'b1; ex_mc_len = 6'd1; #1;
    n_cmp++; if (stall !== 6'b111111) begin n_err++; $display("FAIL eret_detect_stall got=%b exp=111111", stall); end
    next_cycle();
    clear_inputs(); #1;
    n_cmp++; if (stall !== 6'b111111) begin n_err++; $display("FAIL eret_freeze_stall got=%b exp=111111", stall); end
    next_cycle();
    n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL eret_flush got=%b exp=1", flush); end
    n_cmp++; if (new_pc !== 32'h0000_1234) begin n_err++; $display("FAIL eret_new_pc got=%h exp=00001234", new_pc); end
    next_cycle();
    n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL eret_after_flush got=%b exp=0", flush); end
    n_cmp++; if (ex_mc_done !== 1'b0) begin n_err++; $display("FAIL eret_no_mc_done got=%b exp=0", ex_mc_done); end
  endtask

  task automatic test_watchdog();
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      stallreq_if = 1'b1; #1;
      n_cmp++; if (stall_timeout !== 1'b0) begin n_err++; $display("FAIL wd_pre%0d got=%b exp=0", i, stall_timeout); end
    end
    next_cycle();
    stallreq_if = 1'b0; #1;
    n_cmp++; if (stall_timeout !== 1'b1) begin n_err++; $display("FAIL wd_set got=%b exp=1", stall_timeout); end
    next_cycle();
    n_cmp++; if (stall_timeout !== 1'b1) begin n_err++; $display("FAIL wd_sticky got=%b exp=1", stall_timeout); end
    excepttype_i = 32'h0000_0008; #1;
    next_cycle();
    clear_inputs(); #1;
    n_cmp++; if (stall_timeout !== 1'b1) begin n_err++; $display("FAIL wd_freeze_hold got=%b exp=1", stall_timeout); end
    next_cycle();
    n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL wd_flush got=%b exp=1", flush); end
    next_cycle();
    n_cmp++; if (stall_timeout !== 1'b0) begin n_err++; $display("FAIL wd_flush_clear got=%b exp=0", stall_timeout); end
    for (int i = 0; i < 9; i++) begin
      next_cycle();
      stallreq_if = 1'b1;
    end
    #1;
    n_cmp++; if (stall_timeout !== 1'b1) begin n_err++; $display("FAIL wd_reset_pre got=%b exp=1", stall_timeout); end
    rst = 1'b0; #1;
    n_cmp++; if (stall_timeout !== 1'b0) begin n_err++; $display("FAIL wd_async_clear got=%b exp=0", stall_timeout); end
    n_cmp++; if (stall !== 6'b000000) begin n_err++; $display("FAIL wd_rst_stall got=%b exp=000000", stall); end
    next_cycle();
    rst = 1'b1; #1;
    for (int i = 1; i < 8; i++) begin
      next_cycle();
      n_cmp++; if (stall_timeout !== 1'b0) begin n_err++; $display("FAIL wd_recount%0d got=%b exp=0", i, stall_timeout); end
    end
    next_cycle();
    n_cmp++; if (stall_timeout !== 1'b1) begin n_err++; $display("FAIL wd_reset_reach got=%b exp=1", stall_timeout); end
    clear_inputs();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_madd();
    test_len_zero();
    test_mc_mem_stall();
    test_exception();
    test_eret();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
